// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: pointer comparison functions used
// to derive the registered full/empty flags from wrap-bit pointers.
package fifo_pkg;

  localparam int PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_ext_t;

  // Pointers are zero-extended into ptr_ext_t so one function serves any depth.
  function automatic logic ptr_empty(input ptr_ext_t wr, input ptr_ext_t rd);
    return wr == rd;
  endfunction

  // Full when the address bits match but the wrap bit (bit addr_w) differs.
  function automatic logic ptr_full(input ptr_ext_t wr, input ptr_ext_t rd, input int addr_w);
    ptr_ext_t diff;
    ptr_ext_t mask;
    diff = wr ^ rd;
    mask = (ptr_ext_t'(1) << addr_w) - ptr_ext_t'(1);
    return ((diff & mask) == '0) && (((diff >> addr_w) & ptr_ext_t'(1)) != '0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for the FIFO: synchronous write, registered read.
// The array itself is never reset; only the read register clears.
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // rd_data holds its last value whenever no read is accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/fifo_sync_core.sv
// Single-clock FIFO: wrap-bit pointers, registered full/empty/almost flags,
// occupancy count and sticky overflow/underflow error bits.
module fifo_sync_core
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int PTR_W    = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W-1:0]  count,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] count_reg, count_next;
  logic             full_reg, full_next;
  logic             empty_reg, empty_next;
  logic             afull_reg, afull_next;
  logic             aempty_reg, aempty_next;
  logic             overflow_reg, overflow_next;
  logic             underflow_reg, underflow_next;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses only the registered flags, so a blocked access never moves a pointer.
  always_comb begin
    wr_acc         = wr_en & ~full_reg;
    rd_acc         = rd_en & ~empty_reg;
    wr_ptr_next    = wr_ptr_reg + PTR_W'(wr_acc);
    rd_ptr_next    = rd_ptr_reg + PTR_W'(rd_acc);
    count_next     = wr_ptr_next - rd_ptr_next;
    full_next      = ptr_full(ptr_ext_t'(wr_ptr_next), ptr_ext_t'(rd_ptr_next), ADDR_W);
    empty_next     = ptr_empty(ptr_ext_t'(wr_ptr_next), ptr_ext_t'(rd_ptr_next));
    afull_next     = count_next >= PTR_W'(AFULL_TH);
    aempty_next    = count_next <= PTR_W'(AEMPTY_TH);
    // A set event outranks err_clr in the same cycle.
    overflow_next  = (wr_en & full_reg)  | (overflow_reg  & ~err_clr);
    underflow_next = (rd_en & empty_reg) | (underflow_reg & ~err_clr);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      full_reg      <= full_next;
      empty_reg     <= empty_next;
      afull_reg     <= afull_next;
      aempty_reg    <= aempty_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  assign wr_ptr       = wr_ptr_reg;
  assign rd_ptr       = rd_ptr_reg;
  assign count        = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_sync_core.sv
// Randomised and directed bench for fifo_sync_core: a queue-based reference
// model feeds a scoreboard that a separate negedge monitor drains and checks.
module tb_fifo_sync_core;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 5;

  logic              clock;
  logic              resetn;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full, empty, almost_full, almost_empty;
  logic [PTR_W-1:0]  count, wr_ptr, rd_ptr;
  logic              overflow, underflow;
  logic              err_clr;

  fifo_sync_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (12),
    .AEMPTY_TH (4)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: FIFO contents as a queue plus total accepted-access counts.
  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] held_data;
  int                wr_total, rd_total;
  bit                m_ovf, m_udf;
  int                checks, errors, txn;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clock) begin
    if (resetn) begin
      check("count",        32'(count),        32'(model_q.size()));
      check("wr_ptr",       32'(wr_ptr),       32'(wr_total % (2 * DEPTH)));
      check("rd_ptr",       32'(rd_ptr),       32'(rd_total % (2 * DEPTH)));
      check("full",         32'(full),         32'(model_q.size() == DEPTH));
      check("empty",        32'(empty),        32'(model_q.size() == 0));
      check("almost_full",  32'(almost_full),  32'(model_q.size() >= 12));
      check("almost_empty", 32'(almost_empty), 32'(model_q.size() <= 4));
      check("overflow",     32'(overflow),     32'(m_ovf));
      check("underflow",    32'(underflow),    32'(m_udf));
      if (exp_q.size() > 0) begin
        held_data = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(held_data));
      end else begin
        check("rd_hold", 32'(rd_data), 32'(held_data));
      end
    end
  end

  task automatic step(input logic we, input logic [DATA_W-1:0] wd, input logic re, input logic ec);
    bit wa, ra, ov_set, un_set;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    err_clr = ec;
    wa      = we && (model_q.size() < DEPTH);
    ra      = re && (model_q.size() > 0);
    ov_set  = we && (model_q.size() == DEPTH);
    un_set  = re && (model_q.size() == 0);
    @(posedge clock);
    #1;
    if (ra) begin
      exp_q.push_back(model_q.pop_front());
      rd_total++;
    end
    if (wa) begin
      model_q.push_back(wd);
      wr_total++;
    end
    m_ovf = ov_set | (m_ovf & !ec);
    m_udf = un_set | (m_udf & !ec);
    txn++;
    $display("txn %0d we=%b wd=%02h re=%b clr=%b wacc=%b racc=%b occ=%0d",
             txn, we, wd, re, ec, wa, ra, model_q.size());
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
  endtask

  // Asynchronous reset: outputs are checked before any clock edge arrives.
  task automatic do_reset();
    resetn = 1'b0;
    #2;
    check("rst_wr_ptr", 32'(wr_ptr),       32'd0);
    check("rst_rd_ptr", 32'(rd_ptr),       32'd0);
    check("rst_count",  32'(count),        32'd0);
    check("rst_empty",  32'(empty),        32'd1);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_full",   32'(full),         32'd0);
    check("rst_afull",  32'(almost_full),  32'd0);
    check("rst_ovf",    32'(overflow),     32'd0);
    check("rst_udf",    32'(underflow),    32'd0);
    check("rst_rdata",  32'(rd_data),      32'd0);
    model_q.delete();
    exp_q.delete();
    held_data = '0;
    wr_total  = 0;
    rd_total  = 0;
    m_ovf     = 1'b0;
    m_udf     = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; txn = 0;
    resetn = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
    held_data = '0; wr_total = 0; rd_total = 0; m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    do_reset();

    // Fill to full, then push against full and clear the error.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Drain completely; data must come out 0x00..0x0F.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Both requests while empty: write wins, read flags underflow, no fall-through.
    step(1'b1, 8'hA5, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Half-full streaming: both ports busy, pointers wrap several times.
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);

    // Full with both requests: read wins, write overflows.
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Drop to 9 entries and reset mid-burst, then refill through both thresholds.
    while (model_q.size() > 9) step(1'b0, 8'h00, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);

    // Randomised traffic, alternating write-heavy and read-heavy phases.
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 80; i++) begin
        int wp;
        wp = (blk % 2 == 0) ? 70 : 30;
        step(($urandom_range(0, 99) < wp), 8'($urandom),
             ($urandom_range(0, 99) < (100 - wp)), ($urandom_range(0, 99) < 5));
      end
    end

    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
